// File: rtl/product_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : product_acc_pkg
// Description : Shared types and constants for the product accumulator.
//               ACC_W     - accumulator width (sum of up to 255 8-bit products)
//               DATA_W    - width of one product / one output byte
//               CNT_W     - width of the per-result product counter
//               acc_state_t - ACCUM / SEND_LO / SEND_HI control states
// Revision    : 1.0 - initial release
// ============================================================================
package product_acc_pkg;

    localparam int ACC_W  = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } acc_state_t;

endpackage : product_acc_pkg
`default_nettype wire

// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator_if
// Description : Bundle of the accumulator's data-path and control signals.
//               master : upstream/downstream side (drives ena, clear, input
//                        stream and out_ready)
//               slave  : the accumulator (drives in_ready and output stream)
//               Signals: ena, clear, in_data[7:0], in_valid, in_ready,
//                        out_data[7:0], out_hi, out_valid, out_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface product_accumulator_if;
    import product_acc_pkg::*;

    logic              ena;
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_hi;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ena,
        output clear,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_hi,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  ena,
        input  clear,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_hi,
        output out_valid,
        input  out_ready
    );

endinterface : product_accumulator_if
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums DEPTH unsigned 8-bit products into a 16-bit result and
//               returns it as two byte beats (low byte, then high byte) over
//               a valid/ready stream. No new product is accepted until the
//               high byte has been taken.
//               Params : DEPTH (1..255) products per result
//               Ports  : clk   - clock, rising edge
//                        rst_n - asynchronous active-low reset
//                        bus   - product_accumulator_if.slave
//                                (ena, clear, in_*, out_*)
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    product_accumulator_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEPTH - 1);

    acc_state_t        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_valid;
    logic              w_out_xfer;
    logic [DATA_W-1:0] w_out_data;
    logic              w_out_hi;

    // Handshake qualifiers: ena gates both directions so a disabled block
    // neither accepts nor offers data.
    assign w_in_ready  = bus.ena && (r_state == ACCUM);
    assign w_out_valid = bus.ena && (r_state != ACCUM);
    assign w_in_xfer   = bus.in_valid && w_in_ready;
    assign w_out_xfer  = w_out_valid && bus.out_ready;

    // Output byte is a pure function of the registered state and sum, so it
    // stays stable under backpressure without extra holding registers.
    always_comb begin
        w_out_data = '0;
        w_out_hi   = 1'b0;
        case (r_state)
            SEND_LO: begin
                w_out_data = r_acc[DATA_W-1:0];
                w_out_hi   = 1'b0;
            end
            SEND_HI: begin
                w_out_data = r_acc[ACC_W-1:DATA_W];
                w_out_hi   = 1'b1;
            end
            default: begin
                w_out_data = '0;
                w_out_hi   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (bus.ena) begin
            if (bus.clear) begin
                // Abort wins over any concurrent handshake on this edge.
                r_state <= ACCUM;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ACCUM: begin
                        if (w_in_xfer) begin
                            r_acc <= r_acc + {{(ACC_W-DATA_W){1'b0}}, bus.in_data};
                            r_cnt <= r_cnt + 1'b1;
                            // Last product is folded in on the same edge that
                            // hands over to the output phase.
                            if (r_cnt == c_last) begin
                                r_state <= SEND_LO;
                            end
                        end
                    end
                    SEND_LO: begin
                        if (w_out_xfer) begin
                            r_state <= SEND_HI;
                        end
                    end
                    SEND_HI: begin
                        if (w_out_xfer) begin
                            r_state <= ACCUM;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_hi    = w_out_hi;

endmodule : product_accumulator
`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter DEPTH, default 4, legal range 1..255: the number of products summed per result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port ena, input, 1, design enable; low freezes all state.
REQ-005 SHALL have port in_data, input, 8, unsigned product from the upstream 4x4 array multiplier.
REQ-006 SHALL have port in_valid, input, 1, in_data valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-008 SHALL have port clear, input, 1, synchronous abort of the current sum.
REQ-009 SHALL have port out_data, output, 8, one byte of the 16-bit result.
REQ-010 SHALL have port out_hi, output, 1, 0 = low-byte beat, 1 = high-byte beat.
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts out_data.

Function
REQ-013 SHALL implement states ACCUM, SEND_LO, SEND_HI, held in a 16-bit accumulator acc and an 8-bit count cnt.
REQ-014 SHALL define an input transfer as in_valid && in_ready, and an output transfer as out_valid && out_ready.
REQ-015 SHALL drive in_ready = ena in ACCUM and 0 in SEND_LO and SEND_HI.
REQ-016 SHALL, on each input transfer in ACCUM, set acc <= acc + zero-extended in_data and cnt <= cnt + 1.
REQ-017 SHALL, when the transfer has cnt == DEPTH-1, include that product in acc and enter SEND_LO on the same edge, so out_valid is high in the cycle after the last accept.
REQ-018 SHALL use 16-bit arithmetic with no saturation; 255*255 = 65025 < 65536 guarantees no overflow.
REQ-019 SHALL drive out_valid = ena, out_data = acc[7:0] and out_hi = 0 in SEND_LO; on an output transfer it SHALL go to SEND_HI.
REQ-020 SHALL drive out_valid = ena, out_data = acc[15:8] and out_hi = 1 in SEND_HI; on an output transfer it SHALL go to ACCUM with acc = 0 and cnt = 0.
REQ-021 SHALL keep out_data and out_hi stable while out_valid && !out_ready (backpressure).
REQ-022 SHALL drive out_valid = 0, out_data = 0 and out_hi = 0 in ACCUM.
REQ-023 SHALL, when clear = 1 with ena = 1 in any state, go to ACCUM with acc = 0 and cnt = 0 on the next edge.
REQ-024 SHALL give clear priority over a simultaneous input transfer or output transfer, and SHALL discard that product or beat.
REQ-025 SHALL, when ena = 0, hold state, acc and cnt, force in_ready = 0 and out_valid = 0, and ignore clear.
REQ-026 SHALL need no back-to-back overlap: no input is accepted until the high byte is transferred.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set state = ACCUM, acc = 0 and cnt = 0, giving in_ready = ena, out_valid = 0, out_data = 0 and out_hi = 0.
REQ-028 SHALL discard any partial sum or unsent byte when reset is asserted mid-operation; after release it SHALL start a fresh sum.

Structure
REQ-029 SHALL take its state enumeration and the ACC_W = 16 constant from the shared package product_acc_pkg.
REQ-030 SHALL be a single module with no sub-module; the upstream multiplier is instantiated by the top level, not here.

Verification
REQ-031 SHALL cover, with DEPTH = 4 and products 225, 225, 225, 225 with out_ready = 1: beats 0x84 (out_hi = 0) then 0x03 (out_hi = 1), out_valid first high one cycle after the 4th accept.
REQ-032 SHALL cover backpressure: with the result 0x0384 pending and out_ready = 0 for 3 cycles, out_data holds 0x84 and in_ready stays 0; then 0x84 transfers, followed by 0x03.
REQ-033 SHALL cover clear asserted with the 3rd of the products 10, 20, 30: 30 is discarded; the next products 1, 2, 3, 4 give bytes 0x0A then 0x00.
REQ-034 SHALL cover DEPTH = 1 with product 0xE1: bytes 0xE1 then 0x00; with in_valid held high, the next product is accepted only after the high-byte transfer.
REQ-035 SHALL cover rst_n pulsed low during SEND_HI: out_valid drops asynchronously; products 5, 5, 5, 5 then give bytes 0x14 then 0x00.
REQ-036 SHALL cover ena low for 2 cycles mid-sum: in_ready = 0 and acc unchanged; the final sum is unaffected.
